hazard_fwd_unit: RTL and testbench
==================================

// Module: hazard_fwd_unit
// PURPOSE
//  Parametrised hazard/forwarding unit for the pipelined SCPU; replaces the inline ctrl-side forwarding logic.
//  Keeps its own in-flight scoreboard (one entry per post-ID stage) instead of taking ern/mrn/ewreg/mwreg.
//  From it the unit derives, for ID: N-way bypass selects, load-use stall, multi-cycle (MDU) EX hold and branch flush.
//  Also counts stall cycles for the performance monitor.
// PARAMETERS
//  REG_AW      5   register address width
//  NSTAGE      3   post-ID stages tracked; stage 1=EX ... stage NSTAGE=WB
//  LOAD_STAGE  2   first stage whose load result is forwardable (2=MEM)
//  MDU_LAT     4   EX occupancy, in cycles, of an MDU op (1 = no hold)
//  CNT_W       16  stall counter width
//  FSEL_W      $clog2(NSTAGE+1)  bypass select width (derived, localparam)
// PORTS
//  clk          in   1       clock, rising edge
//  rstn         in   1       asynchronous reset, active low
//  id_valid     in   1       valid instruction in ID
//  id_rs/id_rt  in   REG_AW  ID source registers
//  id_use_rs/rt in   1       ID instruction reads rs / rt
//  id_wreg      in   1       ID instruction writes a GPR
//  id_rn        in   REG_AW  ID destination register
//  id_m2reg     in   1       ID instruction is a load
//  id_mdu       in   1       ID instruction is a multi-cycle MDU op
//  ex_redirect  in   1       branch/jump taken, resolved in EX this cycle
//  stall        out  1       hold PC and IF/ID; ID issues a bubble
//  ex_hold      out  1       hold the ID/EX register; EX/MEM receives a bubble
//  flush        out  1       squash IF/ID and the ID instruction
//  fwda/fwdb    out  FSEL_W  0=regfile, k=result of stage k
//  stall_cnt    out  CNT_W   saturating count of cycles with stall=1
// BEHAVIOUR
//  Reset: all entries invalid, MDU cnt=0, stall_cnt=0; every output reads 0 when in reset.
//  Entry = {v, wreg, rn, m2reg}. A match at stage k: v & wreg & rn!=0 & rn==src & use_src.
//  Bypass: fwdX = k of the YOUNGEST (lowest k) matching stage; 0 if no stage matches. Combinational, same cycle.
//  Result readiness at stage k: ALU/MDU results are ready at k>=1 (an MDU result only once cnt==0);
//    a load result is ready at k>=LOAD_STAGE.
//  Load-use stall: the youngest match is a load at k<LOAD_STAGE. A younger non-load match masks an older load.
//  MDU: when an id_mdu instruction enters EX, cnt<=MDU_LAT-1. ex_hold=(cnt!=0), decrementing each cycle.
//  stall = ex_hold | load_use (for rs or rt), and only when id_valid.
//  Shift each cycle:
//    - stage1 <= issue ? ID entry : bubble, where issue = id_valid & ~stall & ~ex_redirect;
//    - stage k <= stage k-1 for k>=2;
//    - when ex_hold: stage1 keeps its value and stage2 <= bubble;
//    - stage NSTAGE retires.
//  flush = ex_redirect, one cycle; the ID instruction never enters the scoreboard.
//  Redirect+stall in the same cycle: flush wins; the stalled ID instruction is dropped; stall_cnt still counts.
//  Redirect during ex_hold: no flush; ex_redirect is ignored (an MDU op is not a branch).
//  stall_cnt saturates at all-ones.
//  Reset asserted mid-operation: the scoreboard clears at once and in-flight hazards are forgotten.
// STRUCTURE
//  Shared package: scoreboard entry typedef, FWD_RF=0 select constant, default stage indices.
//  Sub-module hfu_match: one per source operand (instantiated twice).
//    Inputs: scoreboard vector, src, use. Outputs: fwd select, load_use.
//  Top level: scoreboard shift register, MDU counter, stall counter.
// TESTING
//  1. add r3 then add r4,r3 -> fwda=1, no stall; one gap -> fwda=2; two gaps -> fwda=3 (WB), none beyond.
//  2. lw r5 then add r6,r5 -> stall=1 for 1 cycle, then fwda=2; sw r5 (uses rt) -> fwdb matches.
//  3. add r7 at stage1 and lw r7 at stage2, consumer of r7 -> fwda=1, no stall.
//  4. MDU op with MDU_LAT=4 -> ex_hold=stall=1 for 3 cycles, then a consumer of its rd gets fwda=1.
//  5. ex_redirect with a load-use stall pending -> flush=1, stage1 bubble next cycle, stall_cnt +1.
//  6. r0 as destination -> fwd=0; rstn low mid-stall -> stall=0, stall_cnt=0; 2^16 stalls -> counter holds 0xFFFF.

Source files
------------

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared types and constants for the hazard/forwarding unit: the in-flight
// scoreboard entry, the regfile bypass select and the default stage indices.
package hazard_fwd_unit_pkg;

    // Register addresses are zero-extended into this width inside the scoreboard.
    localparam int REG_AW_MAX = 8;

    localparam int FWD_RF  = 0;
    localparam int STG_EX  = 1;
    localparam int STG_MEM = 2;
    localparam int STG_WB  = 3;

    typedef struct packed {
        logic                  v;
        logic                  wreg;
        logic [REG_AW_MAX-1:0] rn;
        logic                  m2reg;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

endpackage

// File: rtl/hfu_match.sv
// Per-operand scoreboard search: picks the youngest stage writing the source
// register and flags a load whose data is not yet forwardable.
module hfu_match
    import hazard_fwd_unit_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int NSTAGE     = STG_WB,
    parameter int LOAD_STAGE = STG_MEM,
    parameter int FSEL_W     = $clog2(NSTAGE + 1)
) (
    input  sb_entry_t [NSTAGE-1:0] sb,
    input  logic [REG_AW-1:0]      src,
    input  logic                   use_src,
    output logic [FSEL_W-1:0]      fwd,
    output logic                   load_use
);

    logic [REG_AW_MAX-1:0] src_ext;
    logic                  found;

    assign src_ext = REG_AW_MAX'(src);

    // Scan from the youngest stage so a newer writer masks any older one.
    always_comb begin
        fwd      = FSEL_W'(FWD_RF);
        load_use = 1'b0;
        found    = 1'b0;
        for (int k = 0; k < NSTAGE; k++) begin
            if (!found && use_src && sb[k].v && sb[k].wreg &&
                (sb[k].rn != '0) && (sb[k].rn == src_ext)) begin
                found    = 1'b1;
                fwd      = FSEL_W'(k + 1);
                load_use = sb[k].m2reg && ((k + 1) < LOAD_STAGE);
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding unit: tracks in-flight writers in a private scoreboard and
// derives bypass selects, load-use stall, MDU EX hold, branch flush and a stall counter.
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
#(
    parameter int  REG_AW     = 5,
    parameter int  NSTAGE     = STG_WB,
    parameter int  LOAD_STAGE = STG_MEM,
    parameter int  MDU_LAT    = 4,
    parameter int  CNT_W      = 16,
    localparam int FSEL_W     = $clog2(NSTAGE + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wreg,
    input  logic [REG_AW-1:0] id_rn,
    input  logic              id_m2reg,
    input  logic              id_mdu,
    input  logic              ex_redirect,
    output logic              stall,
    output logic              ex_hold,
    output logic              flush,
    output logic [FSEL_W-1:0] fwda,
    output logic [FSEL_W-1:0] fwdb,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int MDU_CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;

    sb_entry_t [NSTAGE-1:0] sb;
    sb_entry_t              id_entry;
    logic [MDU_CW-1:0]      mdu_cnt;
    logic                   lu_a;
    logic                   lu_b;
    logic                   redirect;
    logic                   issue;

    hfu_match #(
        .REG_AW     (REG_AW),
        .NSTAGE     (NSTAGE),
        .LOAD_STAGE (LOAD_STAGE),
        .FSEL_W     (FSEL_W)
    ) u_match_a (
        .sb       (sb),
        .src      (id_rs),
        .use_src  (id_use_rs),
        .fwd      (fwda),
        .load_use (lu_a)
    );

    hfu_match #(
        .REG_AW     (REG_AW),
        .NSTAGE     (NSTAGE),
        .LOAD_STAGE (LOAD_STAGE),
        .FSEL_W     (FSEL_W)
    ) u_match_b (
        .sb       (sb),
        .src      (id_rt),
        .use_src  (id_use_rt),
        .fwd      (fwdb),
        .load_use (lu_b)
    );

    assign ex_hold  = (mdu_cnt != '0);
    // The op held in EX is an MDU op, so a redirect seen during the hold is spurious.
    assign redirect = ex_redirect & ~ex_hold;
    assign flush    = redirect & rstn;
    assign stall    = id_valid & (ex_hold | lu_a | lu_b);
    assign issue    = id_valid & ~stall & ~redirect;

    always_comb begin
        id_entry       = SB_BUBBLE;
        id_entry.v     = 1'b1;
        id_entry.wreg  = id_wreg;
        id_entry.rn    = REG_AW_MAX'(id_rn);
        id_entry.m2reg = id_m2reg;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sb <= '0;
        end else begin
            for (int k = NSTAGE - 1; k >= 1; k--) begin
                sb[k] <= sb[k-1];
            end
            // A held EX keeps its op and hands MEM a bubble instead.
            if (ex_hold) begin
                sb[1] <= SB_BUBBLE;
            end else begin
                sb[0] <= issue ? id_entry : SB_BUBBLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mdu_cnt <= '0;
        end else if (issue && id_mdu) begin
            mdu_cnt <= MDU_CW'(MDU_LAT - 1);
        end else if (ex_hold) begin
            mdu_cnt <= mdu_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: per-cycle expected outputs are queued as
// each ID instruction is driven and popped for comparison before the next edge.
module tb_hazard_fwd_unit;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic       wreg;
        logic [4:0] rn;
        logic       m2reg;
        logic       mdu;
    } ins_t;

    typedef struct packed {
        logic       stall;
        logic       hold;
        logic       flush;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn;
    ins_t        ins;
    logic        redir;
    logic        stall, ex_hold, flush;
    logic [1:0]  fwda, fwdb;
    logic [15:0] stall_cnt;

    ins_t        s_ins;
    logic        s_stall, s_hold, s_flush;
    logic [1:0]  s_fwda, s_fwdb;
    logic [15:0] s_cnt;

    exp_t        q[$];
    int          nerr = 0;
    int          nchk = 0;
    int          nstep = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit dut (
        .clk         (clk),
        .rstn        (rstn),
        .id_valid    (ins.v),
        .id_rs       (ins.rs),
        .id_rt       (ins.rt),
        .id_use_rs   (ins.urs),
        .id_use_rt   (ins.urt),
        .id_wreg     (ins.wreg),
        .id_rn       (ins.rn),
        .id_m2reg    (ins.m2reg),
        .id_mdu      (ins.mdu),
        .ex_redirect (redir),
        .stall       (stall),
        .ex_hold     (ex_hold),
        .flush       (flush),
        .fwda        (fwda),
        .fwdb        (fwdb),
        .stall_cnt   (stall_cnt)
    );

    // Long MDU latency gives one uninterrupted stall run for the saturation check.
    hazard_fwd_unit #(.MDU_LAT(65540)) u_sat (
        .clk         (clk),
        .rstn        (rstn),
        .id_valid    (s_ins.v),
        .id_rs       (s_ins.rs),
        .id_rt       (s_ins.rt),
        .id_use_rs   (s_ins.urs),
        .id_use_rt   (s_ins.urt),
        .id_wreg     (s_ins.wreg),
        .id_rn       (s_ins.rn),
        .id_m2reg    (s_ins.m2reg),
        .id_mdu      (s_ins.mdu),
        .ex_redirect (1'b0),
        .stall       (s_stall),
        .ex_hold     (s_hold),
        .flush       (s_flush),
        .fwda        (s_fwda),
        .fwdb        (s_fwdb),
        .stall_cnt   (s_cnt)
    );

    function automatic ins_t nop();
        return '0;
    endfunction

    function automatic ins_t alu(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        return '{v:1'b1, rs:a, rt:b, urs:1'b1, urt:1'b1, wreg:1'b1, rn:rd, m2reg:1'b0, mdu:1'b0};
    endfunction

    function automatic ins_t ld(input logic [4:0] rd, input logic [4:0] a);
        return '{v:1'b1, rs:a, rt:5'd0, urs:1'b1, urt:1'b0, wreg:1'b1, rn:rd, m2reg:1'b1, mdu:1'b0};
    endfunction

    function automatic ins_t st(input logic [4:0] a, input logic [4:0] b);
        return '{v:1'b1, rs:a, rt:b, urs:1'b1, urt:1'b1, wreg:1'b0, rn:5'd0, m2reg:1'b0, mdu:1'b0};
    endfunction

    function automatic ins_t mul(input logic [4:0] rd, input logic [4:0] a, input logic [4:0] b);
        return '{v:1'b1, rs:a, rt:b, urs:1'b1, urt:1'b1, wreg:1'b1, rn:rd, m2reg:1'b0, mdu:1'b1};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one ID cycle at posedge+1, compare at the following negedge.
    task automatic drive_check(input ins_t i, input logic r, input logic e_stall,
                               input logic e_hold, input logic e_flush,
                               input logic [1:0] e_fa, input logic [1:0] e_fb);
        exp_t e;
        nstep++;
        ins   = i;
        redir = r;
        q.push_back('{stall:e_stall, hold:e_hold, flush:e_flush, fa:e_fa, fb:e_fb});
        #4;
        e = q.pop_front();
        chk($sformatf("s%0d.stall", nstep), 32'(stall),   32'(e.stall));
        chk($sformatf("s%0d.hold",  nstep), 32'(ex_hold), 32'(e.hold));
        chk($sformatf("s%0d.flush", nstep), 32'(flush),   32'(e.flush));
        chk($sformatf("s%0d.fwda",  nstep), 32'(fwda),    32'(e.fa));
        chk($sformatf("s%0d.fwdb",  nstep), 32'(fwdb),    32'(e.fb));
    endtask

    task automatic step(input ins_t i, input logic r, input logic e_stall,
                        input logic e_hold, input logic e_flush,
                        input logic [1:0] e_fa, input logic [1:0] e_fb);
        drive_check(i, r, e_stall, e_hold, e_flush, e_fa, e_fb);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn  = 1'b0;
        ins   = alu(5'd3, 5'd3, 5'd3);
        redir = 1'b1;
        s_ins = nop();
        #2;
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.flush", 32'(flush), 32'd0);
        chk("rst.fwda",  32'(fwda),  32'd0);
        chk("rst.cnt",   32'(stall_cnt), 32'd0);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // back-to-back and gapped ALU forwarding
        step(alu(5'd3, 5'd1, 5'd2),  1'b0, 0, 0, 0, 2'd0, 2'd0);
        step(alu(5'd4, 5'd3, 5'd2),  1'b0, 0, 0, 0, 2'd1, 2'd0);
        step(nop(),                  1'b0, 0, 0, 0, 2'd0, 2'd0);
        step(alu(5'd5, 5'd4, 5'd3),  1'b0, 0, 0, 0, 2'd2, 2'd3);
        step(alu(5'd6, 5'd3, 5'd4),  1'b0, 0, 0, 0, 2'd0, 2'd3);

        // load-use
        step(ld(5'd9, 5'd1),         1'b0, 0, 0, 0, 2'd0, 2'd0);
        step(alu(5'd10, 5'd9, 5'd2), 1'b0, 1, 0, 0, 2'd1, 2'd0);
        step(alu(5'd10, 5'd9, 5'd2), 1'b0, 0, 0, 0, 2'd2, 2'd0);
        step(st(5'd10, 5'd9),        1'b0, 0, 0, 0, 2'd1, 2'd3);
        chk("cnt.after_load_use", 32'(stall_cnt), 32'd1);

        // younger ALU writer masks an older load
        step(ld(5'd7, 5'd1),         1'b0, 0, 0, 0, 2'd0, 2'd0);
        step(alu(5'd7, 5'd1, 5'd2),  1'b0, 0, 0, 0, 2'd0, 2'd0);
        step(alu(5'd11, 5'd7, 5'd7), 1'b0, 0, 0, 0, 2'd1, 2'd1);

        // MDU hold, with a redirect during the hold that must be ignored
        step(mul(5'd12, 5'd11, 5'd2), 1'b0, 0, 0, 0, 2'd1, 2'd0);
        step(alu(5'd13, 5'd12, 5'd0), 1'b0, 1, 1, 0, 2'd1, 2'd0);
        step(alu(5'd13, 5'd12, 5'd0), 1'b1, 1, 1, 0, 2'd1, 2'd0);
        step(alu(5'd13, 5'd12, 5'd0), 1'b0, 1, 1, 0, 2'd1, 2'd0);
        step(alu(5'd13, 5'd12, 5'd0), 1'b0, 0, 0, 0, 2'd1, 2'd0);
        chk("cnt.after_mdu", 32'(stall_cnt), 32'd4);

        // redirect with a pending load-use stall, then a plain redirect
        step(ld(5'd14, 5'd1),          1'b0, 0, 0, 0, 2'd0, 2'd0);
        step(alu(5'd15, 5'd14, 5'd2),  1'b1, 1, 0, 1, 2'd1, 2'd0);
        step(alu(5'd16, 5'd14, 5'd15), 1'b0, 0, 0, 0, 2'd2, 2'd0);
        step(alu(5'd17, 5'd1, 5'd2),   1'b1, 0, 0, 1, 2'd0, 2'd0);
        step(alu(5'd18, 5'd17, 5'd16), 1'b0, 0, 0, 0, 2'd0, 2'd2);
        chk("cnt.after_redirect", 32'(stall_cnt), 32'd5);

        // r0 destination never forwards
        step(alu(5'd0, 5'd1, 5'd2),  1'b0, 0, 0, 0, 2'd0, 2'd0);
        step(alu(5'd19, 5'd0, 5'd0), 1'b0, 0, 0, 0, 2'd0, 2'd0);

        // reset asserted while a load-use stall is showing
        step(ld(5'd20, 5'd1), 1'b0, 0, 0, 0, 2'd0, 2'd0);
        drive_check(alu(5'd21, 5'd20, 5'd2), 1'b0, 1, 0, 0, 2'd1, 2'd0);
        #1;
        rstn = 1'b0;
        #1;
        chk("midrst.stall", 32'(stall),     32'd0);
        chk("midrst.fwda",  32'(fwda),      32'd0);
        chk("midrst.cnt",   32'(stall_cnt), 32'd0);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        drive_check(alu(5'd21, 5'd20, 5'd2), 1'b0, 0, 0, 0, 2'd0, 2'd0);
        @(posedge clk);
        #1;
        chk("midrst.cnt_after", 32'(stall_cnt), 32'd0);
        ins = nop();

        // stall counter saturation on the long-latency instance
        s_ins = mul(5'd1, 5'd2, 5'd3);
        @(posedge clk);
        #1;
        s_ins = '{v:1'b1, rs:5'd0, rt:5'd0, urs:1'b0, urt:1'b0, wreg:1'b0, rn:5'd0, m2reg:1'b0, mdu:1'b0};
        chk("sat.stall_start", 32'(s_stall), 32'd1);
        repeat (65534) @(posedge clk);
        #1;
        chk("sat.cnt_fffe", 32'(s_cnt),   32'h0000_fffe);
        chk("sat.stall_mid", 32'(s_stall), 32'd1);
        repeat (6) @(posedge clk);
        #1;
        chk("sat.cnt_ffff", 32'(s_cnt),   32'h0000_ffff);
        chk("sat.hold_end", 32'(s_hold),  32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
